seq_shift_add_mult: RTL
=======================

Name: seq_shift_add_mult

Overview:
- Iterative shift-and-add multiplier; generalises the team's 4x4 single-cycle shift-add block.
- Generalised to WIDTH-bit operands with a per-operation signed/unsigned mode.
- Uses a start/busy/done handshake and processes one multiplier bit per clock.
- Used by datapath controllers that can tolerate multi-cycle latency in exchange for a single adder.

Parameters:
- WIDTH, 8, operand width in bits (>= 2); product is 2*WIDTH bits.

Ports:
- clk  input  1  rising-edge clock; all state updates on posedge.
- reset  input  1  synchronous active-high reset.
- start  input  1  request; sampled only in IDLE.
- signed_mode  input  1  1 = two's-complement operands, 0 = unsigned; latched with start.
- A  input  WIDTH  multiplicand; latched with start.
- B  input  WIDTH  multiplier; latched with start.
- busy  output  1  high while an operation is in progress.
- done  output  1  one-cycle pulse; P valid while high.
- P  output  2*WIDTH  product register; holds last result until the next result or reset.

Behaviour:
- Reset:
  - Synchronous: reset high at a posedge forces state=IDLE, P=0, busy=0, done=0, internal accumulator/counter=0.
  - Overrides everything, including mid-operation; the aborted result is discarded.
- States:
  - IDLE: wait for start.
  - CALC: one multiplier bit consumed per cycle.
  - FINISH: apply sign and publish result.
- IDLE, start=1 at edge E0:
  - Latch the magnitudes |A| and |B| (raw values if signed_mode=0).
  - Latch neg = A[MSB]^B[MSB] when signed_mode=1, else neg=0.
  - Clear the 2*WIDTH-bit accumulator; set the bit counter to 0; busy<=1.
  - If either latched operand is zero, go to FINISH; otherwise go to CALC.
- CALC, each edge:
  - If the multiplier LSB is 1, acc += (multiplicand magnitude zero-extended) << counter.
  - Shift the multiplier right by 1; increment the counter.
  - After the edge that consumes bit WIDTH-1 (edge E_WIDTH), go to FINISH.
- FINISH, exit edge:
  - P <= neg ? -acc : acc (2*WIDTH-bit two's complement).
  - done<=1, busy<=0, go to IDLE.
- Latency:
  - Normal: done high in the cycle after edge E0+WIDTH+1.
  - Zero operand: done high in the cycle after edge E0+1, with P=0 (never -0 issues; neg is ignored when acc=0).
- done is high for exactly one cycle and is deasserted at the next edge unless a new result is published.
- busy and done are never high together.
- start while busy (CALC/FINISH): ignored. There is no queueing, and A, B and signed_mode changes do not affect the operation in flight.
- start in the cycle done is high: the state is IDLE, so start is accepted normally and P keeps the old result until the new FINISH.
- Signed range:
  - The most-negative operand magnitude 2^(WIDTH-1) is held in an unsigned WIDTH-bit register.
  - The product (-2^(WIDTH-1))^2 = 2^(2WIDTH-2) fits P without overflow.
- No overflow or saturation is possible; all arithmetic is done at 2*WIDTH bits.

Test Plan:
- WIDTH=8, unsigned, A=13, B=11, start 1 cycle -> busy for 9 cycles, then done pulse 1 cycle with P=16'h008F; P holds after done falls.
- Unsigned A=255, B=255 -> P=16'hFE01. Signed A=8'h80 (-128), B=8'h80 -> P=16'h4000. Signed A=-3 (8'hFD), B=5 -> P=16'hFFF1 (-15). Unsigned A=8'hFD, B=5 -> P=16'h04F1.
- A=0, B=200 (and A=77, B=0) -> done 2 edges after start with P=0; signed A=0, B=-1 -> P=0.
- Start held high continuously while A/B change every cycle -> operands are latched only at IDLE acceptance; back-to-back results appear every WIDTH+2 cycles, each matching the operands present at its accept edge.
- Reset asserted 4 cycles into CALC -> next edge busy=0, done=0, P=0; no done pulse follows; a new start after reset yields a correct product.
- Randomised: 1000 random A/B/signed_mode, checked against a behavioural reference product -> all match, and done-pulse timing is exactly WIDTH+1 (or 1 for zero operands) edges after accept.

Source files
------------

// File: rtl/seq_shift_add_mult.sv
`default_nettype none
// ============================================================================
// Module      : seq_shift_add_mult
// Description : Iterative shift-and-add multiplier. It takes WIDTH-bit
//               operands in signed or unsigned mode, consumes one multiplier
//               bit per clock with a single adder, and uses a start/busy/done
//               handshake. The product register is 2*WIDTH bits wide.
// Revision    : 1.0 - initial release
// ============================================================================
module seq_shift_add_mult #(
    parameter int WIDTH = 8
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic               signed_mode,
    input  logic [WIDTH-1:0]   A,
    input  logic [WIDTH-1:0]   B,
    output logic               busy,
    output logic               done,
    output logic [2*WIDTH-1:0] P
);

    // The counter only has to reach WIDTH-1. It may wrap after the last bit,
    // and that is harmless.
    localparam int                 c_CNT_W    = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [c_CNT_W-1:0] c_LAST_BIT = c_CNT_W'(WIDTH - 1);

    localparam logic [1:0] c_ST_IDLE   = 2'd0;
    localparam logic [1:0] c_ST_CALC   = 2'd1;
    localparam logic [1:0] c_ST_FINISH = 2'd2;

    logic [1:0]         r_state;
    logic [WIDTH-1:0]   r_mcand;   // multiplicand magnitude
    logic [WIDTH-1:0]   r_mplr;    // multiplier magnitude, shifted right each step
    logic               r_neg;     // sign to apply to the magnitude product
    logic [2*WIDTH-1:0] r_acc;
    logic [c_CNT_W-1:0] r_cnt;

    logic [WIDTH-1:0]   w_mag_a;
    logic [WIDTH-1:0]   w_mag_b;
    logic               w_neg;
    logic [2*WIDTH-1:0] w_addend;

    // Operand magnitudes and the result sign. -2^(WIDTH-1) maps to itself,
    // and that value is correct when read as an unsigned magnitude.
    always_comb begin
        w_mag_a  = (signed_mode && A[WIDTH-1]) ? ({WIDTH{1'b0}} - A) : A;
        w_mag_b  = (signed_mode && B[WIDTH-1]) ? ({WIDTH{1'b0}} - B) : B;
        w_neg    = signed_mode & (A[WIDTH-1] ^ B[WIDTH-1]);
        w_addend = {{WIDTH{1'b0}}, r_mcand} << r_cnt;
    end

    // Control FSM, datapath and registered handshake outputs
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= c_ST_IDLE;
            r_mcand <= '0;
            r_mplr  <= '0;
            r_neg   <= 1'b0;
            r_acc   <= '0;
            r_cnt   <= '0;
            busy    <= 1'b0;
            done    <= 1'b0;
            P       <= '0;
        end else begin
            done <= 1'b0;
            case (r_state)
                c_ST_IDLE: begin
                    if (start) begin
                        r_mcand <= w_mag_a;
                        r_mplr  <= w_mag_b;
                        r_neg   <= w_neg;
                        r_acc   <= '0;
                        r_cnt   <= '0;
                        busy    <= 1'b1;
                        // A zero operand skips the bit loop. The accumulator
                        // stays zero, so the sign has no effect.
                        if ((w_mag_a == '0) || (w_mag_b == '0)) begin
                            r_state <= c_ST_FINISH;
                        end else begin
                            r_state <= c_ST_CALC;
                        end
                    end
                end

                c_ST_CALC: begin
                    if (r_mplr[0]) begin
                        r_acc <= r_acc + w_addend;
                    end
                    r_mplr <= r_mplr >> 1;
                    r_cnt  <= r_cnt + 1'b1;
                    if (r_cnt == c_LAST_BIT) begin
                        r_state <= c_ST_FINISH;
                    end
                end

                c_ST_FINISH: begin
                    P       <= r_neg ? ({2*WIDTH{1'b0}} - r_acc) : r_acc;
                    done    <= 1'b1;
                    busy    <= 1'b0;
                    r_state <= c_ST_IDLE;
                end

                default: begin
                    r_state <= c_ST_IDLE;
                    busy    <= 1'b0;
                end
            endcase
        end
    end

endmodule
`default_nettype wire
